// File: rtl/mastermind_pkg.sv
// mastermind_pkg
//   Shared definitions for the Mastermind game tracker slice.
//   - PEGS / COLOR_W : default code geometry (pegs per code, bits per peg colour)
//   - FB_W           : width of the red/white feedback counts
//   - CNT_W          : width of turn counters and history indices
//   - game_state_e   : game state encodings as seen on the game_state port
package mastermind_pkg;

    localparam int unsigned PEGS    = 4;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned FB_W    = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_PLAYING = 2'd0,
        ST_WON     = 2'd1,
        ST_LOST    = 2'd2
    } game_state_e;

endpackage

// File: rtl/mastermind_history_ram.sv
// mastermind_history_ram
//   Per-turn history store: DEPTH entries of {guess, red, white}, one write
//   port and one registered read port. Owns a valid bit per entry so that a
//   new game can hide old history without touching the data array.
// Ports
//   clk, resetn       clock, synchronous active-low reset
//   clear_valid_i     clears every valid bit (data is kept)
//   we_i, waddr_i     write enable and entry index
//   wguess_i          guess to store
//   wred_i, wwhite_i  feedback counts to store
//   rsel_i            entry index to read
//   rvalid_o          registered: selected entry holds a turn of this game
//   rguess_o          registered guess, 0 when !rvalid_o
//   rred_o, rwhite_o  registered feedback counts, 0 when !rvalid_o
module mastermind_history_ram
    import mastermind_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GW    = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_valid_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] waddr_i,
    input  logic [GW-1:0]    wguess_i,
    input  logic [FB_W-1:0]  wred_i,
    input  logic [FB_W-1:0]  wwhite_i,
    input  logic [CNT_W-1:0] rsel_i,
    output logic             rvalid_o,
    output logic [GW-1:0]    rguess_o,
    output logic [FB_W-1:0]  rred_o,
    output logic [FB_W-1:0]  rwhite_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [GW-1:0]   guess_mem [DEPTH];
    logic [FB_W-1:0] red_mem   [DEPTH];
    logic [FB_W-1:0] white_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic          wa_ok;
    logic          rd_hit;

    always_comb begin
        wa     = waddr_i[AW-1:0];
        ra     = rsel_i[AW-1:0];
        wa_ok  = waddr_i < CNT_W'(DEPTH);
        // Range check first: the truncated index alone could alias a valid entry.
        rd_hit = (rsel_i < CNT_W'(DEPTH)) && valid_q[ra];
    end

    always_ff @(posedge clk) begin
        if (we_i && wa_ok) begin
            guess_mem[wa] <= wguess_i;
            red_mem[wa]   <= wred_i;
            white_mem[wa] <= wwhite_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear_valid_i) begin
            valid_q <= '0;
        end else if (we_i && wa_ok) begin
            valid_q[wa] <= 1'b1;
        end
    end

    // Read samples the pre-edge array and valid bits, so a same-edge write
    // is not visible until the following read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_o <= 1'b0;
            rguess_o <= '0;
            rred_o   <= '0;
            rwhite_o <= '0;
        end else if (rd_hit) begin
            rvalid_o <= 1'b1;
            rguess_o <= guess_mem[ra];
            rred_o   <= red_mem[ra];
            rwhite_o <= white_mem[ra];
        end else begin
            rvalid_o <= 1'b0;
            rguess_o <= '0;
            rred_o   <= '0;
            rwhite_o <= '0;
        end
    end

endmodule

// File: rtl/mastermind_game_tracker.sv
// mastermind_game_tracker
//   Consumes one red/white feedback result per turn, counts turns, decides
//   WON/LOST, keeps a best (fewest-turns) score and a per-turn history that
//   is read back by index.
// Ports
//   clk, resetn    clock, synchronous active-low reset
//   new_game       pulse: restart game (best score and history data kept)
//   fb_valid       pulse: guess_in/red_in/white_in are final
//   guess_in       guess being scored, peg0 in LSBs
//   red_in         right colour, right position
//   white_in       right colour, wrong position
//   hist_sel       history index to read (0 = first turn)
//   guess_ready    1 while PLAYING
//   game_state     0 PLAYING, 1 WON, 2 LOST
//   turn_count     turns accepted this game
//   best_turns     fewest turns of any won game, 0 = none yet
//   fb_error       sticky flag for illegal feedback (red+white > PEGS)
//   hist_valid     registered: hist_sel < turn_count
//   hist_guess/red/white  registered history entry, 0 when !hist_valid
module mastermind_game_tracker
    import mastermind_pkg::*;
#(
    parameter int unsigned MAX_GUESSES = 8,
    parameter int unsigned PEGS        = mastermind_pkg::PEGS,
    parameter int unsigned COLOR_W     = mastermind_pkg::COLOR_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    new_game,
    input  logic                    fb_valid,
    input  logic [PEGS*COLOR_W-1:0] guess_in,
    input  logic [FB_W-1:0]         red_in,
    input  logic [FB_W-1:0]         white_in,
    input  logic [CNT_W-1:0]        hist_sel,
    output logic                    guess_ready,
    output logic [1:0]              game_state,
    output logic [CNT_W-1:0]        turn_count,
    output logic [CNT_W-1:0]        best_turns,
    output logic                    fb_error,
    output logic                    hist_valid,
    output logic [PEGS*COLOR_W-1:0] hist_guess,
    output logic [FB_W-1:0]         hist_red,
    output logic [FB_W-1:0]         hist_white
);

    localparam int unsigned GW = PEGS * COLOR_W;

    game_state_e      state_q, state_d;
    logic [CNT_W-1:0] turn_q, turn_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic             fb_err_q, fb_err_d;

    logic [CNT_W-1:0] fb_sum;
    logic [CNT_W-1:0] turn_inc;
    logic             playing;
    logic             fb_legal;
    logic             accept;
    logic             illegal;
    logic             win;

    always_comb begin
        // 4-bit sum so 7+7 cannot wrap into the legal range.
        fb_sum   = CNT_W'(red_in) + CNT_W'(white_in);
        fb_legal = fb_sum <= CNT_W'(PEGS);
        playing  = state_q == ST_PLAYING;
        // new_game has priority: coincident feedback is dropped entirely.
        accept   = fb_valid && playing && fb_legal && !new_game;
        illegal  = fb_valid && playing && !fb_legal && !new_game;
        win      = red_in == FB_W'(PEGS);
        turn_inc = turn_q + CNT_W'(1);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_PLAYING;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; win is checked before the last-turn loss
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = ST_PLAYING;
        end else if (accept) begin
            if (win) begin
                state_d = ST_WON;
            end else if (turn_inc == CNT_W'(MAX_GUESSES)) begin
                state_d = ST_LOST;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        guess_ready = playing;
        game_state  = state_q;
    end

    always_comb begin
        turn_d   = turn_q;
        best_d   = best_q;
        fb_err_d = fb_err_q;
        if (new_game) begin
            turn_d   = '0;
            fb_err_d = 1'b0;
        end else begin
            if (accept) begin
                turn_d = turn_inc;
                if (win && ((best_q == '0) || (turn_inc < best_q))) begin
                    best_d = turn_inc;
                end
            end
            if (illegal) begin
                fb_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            turn_q   <= '0;
            best_q   <= '0;
            fb_err_q <= 1'b0;
        end else begin
            turn_q   <= turn_d;
            best_q   <= best_d;
            fb_err_q <= fb_err_d;
        end
    end

    assign turn_count = turn_q;
    assign best_turns = best_q;
    assign fb_error   = fb_err_q;

    mastermind_history_ram #(
        .DEPTH (MAX_GUESSES),
        .GW    (GW)
    ) u_hist (
        .clk           (clk),
        .resetn        (resetn),
        .clear_valid_i (new_game),
        .we_i          (accept),
        .waddr_i       (turn_q),
        .wguess_i      (guess_in),
        .wred_i        (red_in),
        .wwhite_i      (white_in),
        .rsel_i        (hist_sel),
        .rvalid_o      (hist_valid),
        .rguess_o      (hist_guess),
        .rred_o        (hist_red),
        .rwhite_o      (hist_white)
    );

endmodule

// File: tb/tb_mastermind_game_tracker.sv
// tb_mastermind_game_tracker
//   Directed stimulus for mastermind_game_tracker. Each stimulus cycle pushes
//   the outputs it expects after the next clock edge into a scoreboard queue;
//   an independent monitor pops and compares them on the falling edge.
module tb_mastermind_game_tracker;
    import mastermind_pkg::*;

    localparam int unsigned MAXG = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        new_game;
    logic        fb_valid;
    logic [11:0] guess_in;
    logic [2:0]  red_in;
    logic [2:0]  white_in;
    logic [3:0]  hist_sel;
    logic        guess_ready;
    logic [1:0]  game_state;
    logic [3:0]  turn_count;
    logic [3:0]  best_turns;
    logic        fb_error;
    logic        hist_valid;
    logic [11:0] hist_guess;
    logic [2:0]  hist_red;
    logic [2:0]  hist_white;

    always #5 clk = ~clk;

    mastermind_game_tracker #(
        .MAX_GUESSES (MAXG),
        .PEGS        (4),
        .COLOR_W     (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .new_game    (new_game),
        .fb_valid    (fb_valid),
        .guess_in    (guess_in),
        .red_in      (red_in),
        .white_in    (white_in),
        .hist_sel    (hist_sel),
        .guess_ready (guess_ready),
        .game_state  (game_state),
        .turn_count  (turn_count),
        .best_turns  (best_turns),
        .fb_error    (fb_error),
        .hist_valid  (hist_valid),
        .hist_guess  (hist_guess),
        .hist_red    (hist_red),
        .hist_white  (hist_white)
    );

    typedef enum int {S_STATE, S_TURN, S_BEST, S_ERR, S_READY, S_HV, S_HG, S_HR, S_HW} sig_e;
    typedef struct {
        int unsigned due;
        string       name;
        sig_e        sig;
        int unsigned expv;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned act;
    bit          done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned actual(input sig_e s);
        case (s)
            S_STATE: return 32'(game_state);
            S_TURN:  return 32'(turn_count);
            S_BEST:  return 32'(best_turns);
            S_ERR:   return 32'(fb_error);
            S_READY: return 32'(guess_ready);
            S_HV:    return 32'(hist_valid);
            S_HG:    return 32'(hist_guess);
            S_HR:    return 32'(hist_red);
            default: return 32'(hist_white);
        endcase
    endfunction

    // Monitor: compares every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            n_checks++;
            act = actual(cur.sig);
            if (cur.due != cyc) begin
                $display("FAIL %s: missed at cycle %0d (due %0d)", cur.name, cyc, cur.due);
            end else if (act == cur.expv) begin
                n_pass++;
            end else begin
                $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", cur.name, cyc, act, cur.expv);
            end
        end
        if (done) begin
            while (sb.size() > 0) begin
                cur = sb.pop_front();
                n_checks++;
                $display("FAIL %s: never observed (due %0d)", cur.name, cur.due);
            end
        end
    end

    task automatic drive(input logic ng, input logic fv, input logic [11:0] g,
                         input logic [2:0] r, input logic [2:0] w, input logic [3:0] sel);
        new_game = ng;
        fb_valid = fv;
        guess_in = g;
        red_in   = r;
        white_in = w;
        hist_sel = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        new_game = 1'b0;
        fb_valid = 1'b0;
    endtask

    // Expectation for the outputs after the next rising edge.
    task automatic ex(input string n, input sig_e s, input int unsigned v);
        sb.push_back('{due: cyc + 1, name: n, sig: s, expv: v});
    endtask

    task automatic ex_reset(input string tag);
        ex({tag, "_state"}, S_STATE, 0);
        ex({tag, "_turn"},  S_TURN,  0);
        ex({tag, "_best"},  S_BEST,  0);
        ex({tag, "_err"},   S_ERR,   0);
        ex({tag, "_ready"}, S_READY, 1);
        ex({tag, "_hv"},    S_HV,    0);
        ex({tag, "_hg"},    S_HG,    0);
        ex({tag, "_hr"},    S_HR,    0);
        ex({tag, "_hw"},    S_HW,    0);
    endtask

    initial begin
        resetn = 1'b0;
        drive(0, 0, 12'o0000, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset values
        ex_reset("rst");
        tick();
        resetn = 1'b1;

        // First turn and its readback (same-edge read sees pre-write contents)
        drive(0, 1, 12'o1234, 1, 2, 0);
        ex("t1_turn", S_TURN, 1); ex("t1_state", S_STATE, 0); ex("t1_prewrite_hv", S_HV, 0);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 0);
        ex("t1_hv", S_HV, 1); ex("t1_hg", S_HG, 12'o1234); ex("t1_hr", S_HR, 1); ex("t1_hw", S_HW, 2);
        tick();

        // Turns 2..7 miss, turn 8 wins: win has priority over the loss
        for (int i = 1; i <= 6; i++) begin
            drive(0, 1, 12'(i), 0, 1, 0);
            ex("lw_turn", S_TURN, i + 1); ex("lw_state", S_STATE, 0);
            tick();
        end
        drive(0, 1, 12'o7777, 4, 0, 7);
        ex("lw_state8", S_STATE, 1); ex("lw_turn8", S_TURN, 8); ex("lw_best8", S_BEST, 8);
        ex("lw_ready8", S_READY, 0); ex("lw_prewrite_hv", S_HV, 0);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 7);
        ex("lw_hv7", S_HV, 1); ex("lw_hg7", S_HG, 12'o7777); ex("lw_hr7", S_HR, 4);
        tick();

        // Win in 4 turns improves best; feedback after WON is ignored
        drive(1, 0, 12'o0000, 0, 0, 0);
        ex("t2_ng_state", S_STATE, 0); ex("t2_ng_turn", S_TURN, 0); ex("t2_ng_best", S_BEST, 8); ex("t2_ng_ready", S_READY, 1);
        tick();
        drive(0, 1, 12'o1111, 0, 1, 0); ex("t2_turn1", S_TURN, 1); tick();
        drive(0, 1, 12'o2222, 1, 1, 0); ex("t2_turn2", S_TURN, 2); tick();
        drive(0, 1, 12'o3333, 2, 0, 0); ex("t2_turn3", S_TURN, 3); tick();
        drive(0, 1, 12'o4321, 4, 0, 0);
        ex("t2_won", S_STATE, 1); ex("t2_turn4", S_TURN, 4); ex("t2_best4", S_BEST, 4); ex("t2_ready", S_READY, 0);
        tick();
        drive(0, 1, 12'o5555, 3, 2, 3);
        ex("t2_ign_state", S_STATE, 1); ex("t2_ign_turn", S_TURN, 4); ex("t2_ign_err", S_ERR, 0); ex("t2_ign_best", S_BEST, 4);
        tick();
        drive(0, 1, 12'o5555, 1, 1, 3);
        ex("t2_ign2_turn", S_TURN, 4); ex("t2_ign2_state", S_STATE, 1);
        ex("t2_hv3", S_HV, 1); ex("t2_hg3", S_HG, 12'o4321); ex("t2_hr3", S_HR, 4); ex("t2_hw3", S_HW, 0);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 4);
        ex("t2_hv4", S_HV, 0); ex("t2_hg4", S_HG, 0); ex("t2_hw4", S_HW, 0);
        tick();

        // Eight misses -> LOST
        drive(1, 0, 12'o0000, 0, 0, 0);
        ex("t3_ng_turn", S_TURN, 0); ex("t3_ng_state", S_STATE, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 12'o7000 + 12'(i), 3'(i % 4), (i % 4 == 3) ? 3'd1 : 3'd0, 0);
            ex("t3_turn", S_TURN, i + 1);
            ex("t3_state", S_STATE, (i == 7) ? 2 : 0);
            ex("t3_ready", S_READY, (i == 7) ? 0 : 1);
            tick();
        end
        drive(0, 1, 12'o1111, 4, 0, 7);
        ex("t3_ign_state", S_STATE, 2); ex("t3_ign_turn", S_TURN, 8); ex("t3_ign_best", S_BEST, 4); ex("t3_ign_err", S_ERR, 0);
        ex("t3_hv7", S_HV, 1); ex("t3_hg7", S_HG, 12'o7007); ex("t3_hr7", S_HR, 3); ex("t3_hw7", S_HW, 1);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 8);
        ex("t3_hv8", S_HV, 0); ex("t3_hg8", S_HG, 0);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 15);
        ex("t3_hv15", S_HV, 0);
        tick();

        // Illegal feedback, boundary sum == PEGS, new_game clears error
        drive(1, 0, 12'o0000, 0, 0, 0);
        ex("t4_ng_state", S_STATE, 0); ex("t4_ng_turn", S_TURN, 0); ex("t4_ng_err", S_ERR, 0);
        tick();
        drive(0, 1, 12'o1010, 1, 0, 0); ex("t4_turn1", S_TURN, 1); tick();
        drive(0, 1, 12'o2020, 3, 2, 0);
        ex("t4_err", S_ERR, 1); ex("t4_err_turn", S_TURN, 1); ex("t4_err_state", S_STATE, 0); ex("t4_err_ready", S_READY, 1);
        tick();
        drive(0, 1, 12'o3030, 7, 7, 0);
        ex("t4_err77", S_ERR, 1); ex("t4_err77_turn", S_TURN, 1);
        tick();
        drive(0, 1, 12'o4040, 2, 2, 1);
        ex("t4_sum4_turn", S_TURN, 2); ex("t4_sum4_err", S_ERR, 1); ex("t4_sum4_state", S_STATE, 0);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 1);
        ex("t4_hv1", S_HV, 1); ex("t4_hg1", S_HG, 12'o4040); ex("t4_hr1", S_HR, 2); ex("t4_hw1", S_HW, 2);
        tick();
        drive(1, 0, 12'o0000, 0, 0, 0);
        ex("t4_ng2_err", S_ERR, 0); ex("t4_ng2_turn", S_TURN, 0);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 0);
        ex("t4_hv0", S_HV, 0); ex("t4_hg0", S_HG, 0); ex("t4_hr0", S_HR, 0);
        tick();

        // new_game with fb_valid drops the feedback; best improves to 2 then holds
        drive(0, 1, 12'o5555, 1, 0, 0); ex("t5_turn1", S_TURN, 1); tick();
        drive(1, 1, 12'o6666, 4, 0, 0);
        ex("t5_ngfb_turn", S_TURN, 0); ex("t5_ngfb_state", S_STATE, 0); ex("t5_ngfb_best", S_BEST, 4);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 0);
        ex("t5_ngfb_hv", S_HV, 0);
        tick();
        drive(0, 1, 12'o0001, 0, 0, 0); ex("t5_w2_turn1", S_TURN, 1); tick();
        drive(0, 1, 12'o7777, 4, 0, 0);
        ex("t5_w2_state", S_STATE, 1); ex("t5_w2_turn", S_TURN, 2); ex("t5_w2_best", S_BEST, 2);
        ex("t5_hv0", S_HV, 1); ex("t5_hg0", S_HG, 12'o0001);
        tick();
        drive(1, 0, 12'o0000, 0, 0, 0); ex("t5_ng_turn", S_TURN, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 12'o1000 + 12'(i), 1, 1, 0);
            ex("t5_w5_turn", S_TURN, i + 1);
            tick();
        end
        drive(0, 1, 12'o2345, 4, 0, 0);
        ex("t5_w5_state", S_STATE, 1); ex("t5_w5_turn", S_TURN, 5); ex("t5_w5_best", S_BEST, 2);
        tick();

        // Reset mid-session clears best score
        resetn = 1'b0;
        drive(0, 0, 12'o0000, 0, 0, 0);
        ex_reset("rst2");
        tick();
        resetn = 1'b1;
        drive(0, 1, 12'o0001, 0, 0, 0); ex("t6_turn1", S_TURN, 1); tick();
        drive(0, 1, 12'o0002, 0, 0, 0); ex("t6_turn2", S_TURN, 2); tick();
        drive(0, 1, 12'o0003, 4, 0, 0);
        ex("t6_won", S_STATE, 1); ex("t6_best3", S_BEST, 3);
        tick();
        drive(0, 0, 12'o0000, 0, 0, 2);
        ex("t6_hv2", S_HV, 1); ex("t6_hg2", S_HG, 12'o0003);
        tick();
        resetn = 1'b0;
        drive(0, 0, 12'o0000, 0, 0, 2);
        ex_reset("rst3");
        tick();
        resetn = 1'b1;
        drive(0, 0, 12'o0000, 0, 0, 0);
        ex("post_rst_hv", S_HV, 0); ex("post_rst_state", S_STATE, 0);
        tick();

        done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
